// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: connection between the multiply sequencer and the shared
// 8-bit ALU / CPU control unit. It carries the ownership request/grant pair,
// the operand/opcode/enable drives and the ALU result bus and carry flag.
// The master side is the sequencer; the slave side is the ALU/control unit.

interface alu_mul_seq_if;
  logic       o_alu_req;
  logic       i_alu_gnt;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [3:0] o_alu_op;
  logic       o_alu_cin;
  logic       o_alu_sel;
  logic       o_flag_sel;
  logic [7:0] i_alu_data;
  logic       i_alu_co;

  modport master (
    output o_alu_req, o_alu_a, o_alu_b, o_alu_op, o_alu_cin, o_alu_sel, o_flag_sel,
    input  i_alu_gnt, i_alu_data, i_alu_co
  );

  modport slave (
    input  o_alu_req, o_alu_a, o_alu_b, o_alu_op, o_alu_cin, o_alu_sel, o_flag_sel,
    output i_alu_gnt, i_alu_data, i_alu_co
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned 8x8 -> 16 shift-and-add multiplier that borrows the
// shared 8-bit ALU for each partial-product add. The ALU is requested only
// while an add is pending and released again before each shift, so the
// control unit can interleave its own work between iterations.
//
// Optional feature: define MUL_FAST_ZERO_EN to short-circuit a zero operand
// straight to completion without ever touching the ALU.

module alu_mul_seq (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic [7:0]    i_multiplicand,
  input  logic [7:0]    i_multiplier,
  output logic          o_busy,
  output logic          o_done,
  output logic [15:0]   o_product,
  alu_mul_seq_if.master alu
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] ALU_OP_ADD  = 4'h5;
  localparam logic [3:0] ALU_OP_IDLE = 4'h0;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] p_hi_r;
  logic [7:0] p_hi_nxt_s;
  logic [7:0] p_lo_r;
  logic [7:0] p_lo_nxt_s;
  logic [7:0] m_r;
  logic [7:0] m_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  logic       took_add_r;
  logic       took_add_nxt_s;
  logic       busy_r;
  logic       done_r;
  logic       req_r;
  logic       alu_owned_s;
  logic       shift_carry_s;

  // The ALU is actually ours only in ADD with the grant present.
  assign alu_owned_s = (state_r == ST_ADD) && alu.i_alu_gnt;

  // The carry flag belongs to this shift only if the preceding cycle was our add;
  // otherwise the flag holds stale data and a zero is shifted in.
  assign shift_carry_s = took_add_r & alu.i_alu_co;

  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_product     = {p_hi_r, p_lo_r};
  assign alu.o_alu_req = req_r;

  // Next-state and datapath update for the shift-and-add sequence.
  always_comb begin
    state_nxt_s    = state_r;
    p_hi_nxt_s     = p_hi_r;
    p_lo_nxt_s     = p_lo_r;
    m_nxt_s        = m_r;
    cnt_nxt_s      = cnt_r;
    took_add_nxt_s = took_add_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          m_nxt_s        = i_multiplicand;
          p_hi_nxt_s     = 8'h00;
          p_lo_nxt_s     = i_multiplier;
          cnt_nxt_s      = 3'd0;
          took_add_nxt_s = 1'b0;
`ifdef MUL_FAST_ZERO_EN
          if ((i_multiplicand == 8'h00) || (i_multiplier == 8'h00)) begin
            p_lo_nxt_s  = 8'h00;
            state_nxt_s = ST_DONE;
          end else if (i_multiplier[0]) begin
            state_nxt_s = ST_ADD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
`else
          if (i_multiplier[0]) begin
            state_nxt_s = ST_ADD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (alu_owned_s) begin
          p_hi_nxt_s     = alu.i_alu_data;
          took_add_nxt_s = 1'b1;
          state_nxt_s    = ST_SHIFT;
        end else begin
          state_nxt_s = ST_ADD;
        end
      end
      ST_SHIFT: begin
        // The 9-bit {carry, sum} of the previous add is folded in here.
        {p_hi_nxt_s, p_lo_nxt_s} = {shift_carry_s, p_hi_r, p_lo_r[7:1]};
        if (cnt_r == 3'd7) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s      = cnt_r + 3'd1;
          took_add_nxt_s = 1'b0;
          if (p_lo_nxt_s[0]) begin
            state_nxt_s = ST_ADD;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // ALU drives: active only while we own the ALU, idle values otherwise.
  always_comb begin
    alu.o_alu_cin = 1'b0;
    if (alu_owned_s) begin
      alu.o_alu_op   = ALU_OP_ADD;
      alu.o_alu_a    = p_hi_r;
      alu.o_alu_b    = m_r;
      alu.o_alu_sel  = 1'b1;
      alu.o_flag_sel = 1'b1;
    end else begin
      alu.o_alu_op   = ALU_OP_IDLE;
      alu.o_alu_a    = 8'h00;
      alu.o_alu_b    = 8'h00;
      alu.o_alu_sel  = 1'b0;
      alu.o_flag_sel = 1'b0;
    end
  end

  // State, datapath and registered status outputs (decoded from next state).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r    <= ST_IDLE;
      p_hi_r     <= 8'h00;
      p_lo_r     <= 8'h00;
      m_r        <= 8'h00;
      cnt_r      <= 3'd0;
      took_add_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      req_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      p_hi_r     <= p_hi_nxt_s;
      p_lo_r     <= p_lo_nxt_s;
      m_r        <= m_nxt_s;
      cnt_r      <= cnt_nxt_s;
      took_add_r <= took_add_nxt_s;
      busy_r     <= (state_nxt_s == ST_ADD) || (state_nxt_s == ST_SHIFT);
      done_r     <= (state_nxt_s == ST_DONE);
      req_r      <= (state_nxt_s == ST_ADD);
    end
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned 8x8 multiply sequencer that borrows the shared 8-bit ALU to build a 16-bit product by shift-and-add. It sits beside the CPU control unit. It requests the ALU through a request/grant handshake, drives the ALU operand, opcode and enable lines only while granted, and reads the ALU result bus and registered carry flag. Partial-product shifting and iteration counting are local.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  start request; sampled only in IDLE
- i_multiplicand  in  8  operand M; captured on accepted start
- i_multiplier  in  8  operand Q; captured on accepted start
- o_busy  out  1  high in ADD and SHIFT
- o_done  out  1  one-cycle completion pulse
- o_product  out  16  result; held until next accepted start
- o_alu_req  out  1  ALU ownership request
- i_alu_gnt  in  1  ALU ownership grant from control unit
- o_alu_a  out  8  ALU A operand
- o_alu_b  out  8  ALU B operand
- o_alu_op  out  4  ALU opcode
- o_alu_cin  out  1  ALU carry-in; always 0
- o_alu_sel  out  1  ALU output-enable onto bus
- o_flag_sel  out  1  ALU flag-register write enable
- i_alu_data  in  8  ALU result bus
- i_alu_co  in  1  ALU registered carry flag

## Operation
- Registers:
  - P_hi: 8 bits.
  - P_lo: 8 bits.
  - M: 8 bits.
  - cnt: 3-bit iteration counter.
  - took_add: 1 bit.
- o_product = {P_hi, P_lo}.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - i_start=1: load M=i_multiplicand, P_hi=0, P_lo=i_multiplier, cnt=0.
  - Then go to ADD if i_multiplier[0]=1, else go to SHIFT with took_add=0.
- ADD:
  - o_alu_req=1.
  - While i_alu_gnt=0: stay in ADD, all ALU drives idle.
  - While i_alu_gnt=1:
    - Drive o_alu_op=4'h5, o_alu_a=P_hi, o_alu_b=M, o_alu_sel=1, o_flag_sel=1.
    - On that edge: capture P_hi=i_alu_data, set took_add=1, go to SHIFT.
- SHIFT:
  - c = took_add ? i_alu_co : 0. i_alu_co is valid here because it reflects the flag written at the ADD edge.
  - {P_hi, P_lo} = {c, P_hi, P_lo[7:1]}.
  - If cnt=7: go to DONE.
  - Else: cnt=cnt+1, clear took_add, and go to ADD if the new P_lo[0]=1, else to SHIFT.
- DONE:
  - o_done=1 for one cycle, then go to IDLE.
  - i_start in DONE is ignored.
- Idle ALU drives, used whenever not (ADD and i_alu_gnt):
  - o_alu_op=4'h0, o_alu_a=0, o_alu_b=0.
  - o_alu_sel=0, o_flag_sel=0, o_alu_cin=0.
- o_alu_req is low in IDLE, SHIFT and DONE. Ownership is released between iterations.
- i_start while busy is ignored; operands are not re-captured.
- Arithmetic and width rules:
  - The 9-bit {carry, sum} of each add is folded back in by the following shift.
  - Product is exact for all 0x00..0xFF operand pairs. There is no overflow.
- ALU flag state after DONE reflects the last ADD. If Q=0, the sequencer never writes the flags.

## Timing
- Reset values:
  - State IDLE; P_hi, P_lo, M, cnt, took_add all 0.
  - o_busy=0, o_done=0, o_product=0x0000, o_alu_req=0.
  - All ALU drives at their idle values.
- Latency:
  - With the grant never stalling, o_done rises 8 + popcount(Q) edges after the start edge.
  - Each cycle of i_alu_gnt=0 while in ADD adds one cycle.
- o_alu_sel and o_flag_sel are combinational from state and i_alu_gnt. The grant must be stable before mid-cycle.
- o_product is stable from the DONE cycle until the edge that accepts the next start.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. The in-flight result is lost, and ALU ownership drops at once.

## Configuration
- MUL_FAST_ZERO_EN defined:
  - If i_multiplicand=0 or i_multiplier=0 at an accepted start, go directly to DONE with P_hi=P_lo=0.
  - o_done rises 1 edge after start; o_alu_req is never asserted.
- MUL_FAST_ZERO_EN undefined:
  - Zero operands run the normal loop.
  - Q=0 gives 8 edges, no ALU request. M=0 with Q≠0 still requests ALU per set bit.
  - Product is 0x0000 in both cases.

## Test plan
- M=0x0F, Q=0x0D, i_alu_gnt tied 1, behavioural ALU -> o_product=0x00C3, o_done 11 edges after start, three o_flag_sel pulses.
- M=0xFF, Q=0xFF, gnt tied 1 -> o_product=0xFE01, o_done at 16 edges, carry folded on every shift.
- M=0x12, Q=0x01, gnt held low 5 cycles in first ADD -> o_alu_sel/o_flag_sel low during stall, o_product=0x0012, o_done at 14 edges.
- Start M=0x03, Q=0x05, then pulse i_start with M=0xAA, Q=0xAA while busy -> second start ignored, o_product=0x000F.
- Reset at edge 4 of M=0x55, Q=0x33 -> all outputs at reset values, o_alu_req=0 immediately; subsequent start M=0x02, Q=0x03 gives 0x0006.
- M=0x00, Q=0x37 -> product 0x0000, o_done at 1 edge with MUL_FAST_ZERO_EN, at 13 edges without.
